alu_cmd_sequencer: RTL and testbench

//  Initiator side of the salu command interface. Accepts ALU requests on a valid/ready port.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_ref_model.sv | 24 ++
 rtl/alu_cmd_sequencer.sv | 96 +++++++++
 tb/tb_alu_cmd_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, default widths, legal-opcode check and FSM state encoding for the salu sequencer.
package alu_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int CMD_WIDTH = 3;
    localparam logic [CMD_WIDTH-1:0] ALU_ADD = 3'b000;
    localparam logic [CMD_WIDTH-1:0] ALU_SUB = 3'b001;
    localparam logic [CMD_WIDTH-1:0] ALU_XOR = 3'b010;
    localparam logic [CMD_WIDTH-1:0] ALU_AND = 3'b011;
    localparam logic [CMD_WIDTH-1:0] ALU_OR  = 3'b100;
    typedef enum logic [2:0] {IDLE, ISSUE, HOLD, CAPT, RESP} state_t;
    function automatic logic is_legal(input logic [CMD_WIDTH-1:0] cmd);
        return cmd <= ALU_OR;
    endfunction
endpackage

// File: rtl/alu_ref_model.sv
// alu_ref_model: combinational golden model of salu (modulo add/sub, bitwise logic ops).
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int cmd_width = CMD_WIDTH
) (
    input  logic [cmd_width-1:0]  cmd,
    input  logic [data_width-1:0] a,
    input  logic [data_width-1:0] b,
    output logic [data_width-1:0] expected
);
    always_comb begin
        expected = '0;
        case (cmd)
            ALU_ADD: expected = a + b;
            ALU_SUB: expected = a - b;
            ALU_XOR: expected = a ^ b;
            ALU_AND: expected = a & b;
            ALU_OR:  expected = a | b;
            default: expected = '0;
        endcase
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: drives one salu through its 2-edge latency, checks outr against a reference
// model and returns the result on a valid/ready response port.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int cmd_width = CMD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [cmd_width-1:0]  req_cmd,
    input  logic [data_width-1:0] req_a,
    input  logic [data_width-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [data_width-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  rsp_mismatch,
    output logic [cmd_width-1:0]  alu_cmd,
    output logic [data_width-1:0] alu_ain,
    output logic [data_width-1:0] alu_bin,
    input  logic [data_width-1:0] alu_outr,
    output logic                  busy,
    output logic [15:0]           txn_count
);
    state_t state;
    logic [data_width-1:0] expected;

    // The held alu_* registers double as the latched request for the reference model.
    alu_ref_model #(.data_width(data_width), .cmd_width(cmd_width)) u_ref (
        .cmd(alu_cmd),
        .a(alu_ain),
        .b(alu_bin),
        .expected(expected)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            rsp_err <= 1'b0;
            rsp_mismatch <= 1'b0;
            alu_cmd <= '0;
            alu_ain <= '0;
            alu_bin <= '0;
            busy <= 1'b0;
            txn_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        busy <= 1'b1;
                        if (is_legal(req_cmd)) begin
                            alu_cmd <= req_cmd;
                            alu_ain <= req_a;
                            alu_bin <= req_b;
                            state <= ISSUE;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err <= 1'b1;
                            rsp_data <= '0;
                            rsp_mismatch <= 1'b0;
                            state <= RESP;
                        end
                    end
                end
                ISSUE: state <= HOLD;
                // alu_cmd stays untouched here: salu decodes the live cmd on the next edge.
                HOLD: state <= CAPT;
                CAPT: begin
                    rsp_data <= alu_outr;
                    rsp_mismatch <= alu_outr != expected;
                    rsp_err <= 1'b0;
                    rsp_valid <= 1'b1;
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        txn_count <= txn_count + 16'd1;
                        busy <= 1'b0;
                        req_ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed bench with a behavioural salu stub (optional outr fault injection).
module tb_alu_cmd_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [2:0] req_cmd = '0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic rsp_valid;
    logic rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic rsp_err;
    logic rsp_mismatch;
    logic [2:0] alu_cmd;
    logic [15:0] alu_ain;
    logic [15:0] alu_bin;
    logic [15:0] alu_outr = '0;
    logic busy;
    logic [15:0] txn_count;
    logic fault = 1'b0;
    logic [15:0] sa = '0;
    logic [15:0] sb = '0;
    int checks = 0;
    int fails = 0;
    logic [15:0] exp_txn = '0;

    always #5 clk = ~clk;

    alu_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_mismatch(rsp_mismatch),
        .alu_cmd(alu_cmd), .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_outr(alu_outr),
        .busy(busy), .txn_count(txn_count)
    );

    // salu stub: operands registered on one edge, live cmd decoded into outr on the next.
    always @(posedge clk) begin
        sa <= alu_ain;
        sb <= alu_bin;
        case (alu_cmd)
            3'b000: alu_outr <= (sa + sb) ^ {15'd0, fault};
            3'b001: alu_outr <= (sa - sb) ^ {15'd0, fault};
            3'b010: alu_outr <= (sa ^ sb) ^ {15'd0, fault};
            3'b011: alu_outr <= (sa & sb) ^ {15'd0, fault};
            3'b100: alu_outr <= (sa | sb) ^ {15'd0, fault};
            default: alu_outr <= 16'hDEAD;
        endcase
    end

    task automatic issue(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL issue_timeout req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1;
        req_cmd = c;
        req_a = a;
        req_b = b;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_mismatch, busy} !== 5'b0 || rsp_data !== 16'h0 ||
            txn_count !== 16'h0 || alu_cmd !== 3'b0 || alu_ain !== 16'h0 || alu_bin !== 16'h0) begin
            fails++;
            $display("FAIL reset_outputs rdy=%b vld=%b busy=%b data=%h txn=%h cmd=%h ain=%h bin=%h required all 0",
                     req_ready, rsp_valid, busy, rsp_data, txn_count, alu_cmd, alu_ain, alu_bin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release req_ready=%b busy=%b required 1 0", req_ready, busy);
        end
        exp_txn = 16'h0;
    endtask

    task automatic test_add();
        issue(3'b000, 16'hFFFF, 16'h0002);
        checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0 ||
            alu_cmd !== 3'b000 || alu_ain !== 16'hFFFF || alu_bin !== 16'h0002) begin
            fails++;
            $display("FAIL add_issue busy=%b rdy=%b vld=%b cmd=%h ain=%h bin=%h required 1 0 0 0 ffff 0002",
                     busy, req_ready, rsp_valid, alu_cmd, alu_ain, alu_bin);
        end
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || alu_cmd !== 3'b000) begin
                fails++;
                $display("FAIL add_latency edge=%0d rsp_valid=%b alu_cmd=%h required 0 0", i, rsp_valid, alu_cmd);
            end
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h0001 || rsp_err !== 1'b0 || rsp_mismatch !== 1'b0) begin
            fails++;
            $display("FAIL add_result vld=%b data=%h err=%b mm=%b required 1 0001 0 0",
                     rsp_valid, rsp_data, rsp_err, rsp_mismatch);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_txn++;
        checks++;
        if (rsp_valid !== 1'b0 || txn_count !== exp_txn || req_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL add_handshake vld=%b txn=%h rdy=%b busy=%b required 0 %h 1 0",
                     rsp_valid, txn_count, req_ready, busy, exp_txn);
        end
    endtask

    task automatic test_sequence();
        logic [2:0] cmds [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
        logic [15:0] as [4] = '{16'h0003, 16'hF0F0, 16'hF0F0, 16'hF0F0};
        logic [15:0] bs [4] = '{16'h0005, 16'h0FF0, 16'h0FF0, 16'h0FF0};
        logic [15:0] exps [4] = '{16'hFFFE, 16'hFF00, 16'h00F0, 16'hFFF0};
        for (int k = 0; k < 4; k++) begin
            issue(cmds[k], as[k], bs[k]);
            repeat (3) @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exps[k] || rsp_err !== 1'b0 || rsp_mismatch !== 1'b0) begin
                fails++;
                $display("FAIL seq_op%0d vld=%b data=%h err=%b mm=%b required 1 %h 0 0",
                         k, rsp_valid, rsp_data, rsp_err, rsp_mismatch, exps[k]);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            exp_txn++;
            checks++;
            if (txn_count !== exp_txn || rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL seq_txn%0d txn=%h vld=%b required %h 0", k, txn_count, rsp_valid, exp_txn);
            end
        end
    endtask

    task automatic test_error();
        issue(3'b101, 16'h1234, 16'h5678);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 16'h0 || rsp_mismatch !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL err_response vld=%b err=%b data=%h mm=%b busy=%b required 1 1 0000 0 1",
                     rsp_valid, rsp_err, rsp_data, rsp_mismatch, busy);
        end
        checks++;
        if (alu_cmd !== 3'b100 || alu_ain !== 16'hF0F0 || alu_bin !== 16'h0FF0) begin
            fails++;
            $display("FAIL err_alu_held cmd=%h ain=%h bin=%h required 4 f0f0 0ff0", alu_cmd, alu_ain, alu_bin);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_txn++;
        checks++;
        if (txn_count !== exp_txn || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL err_handshake txn=%h vld=%b rdy=%b required %h 0 1", txn_count, rsp_valid, req_ready, exp_txn);
        end
    endtask

    task automatic test_backpressure();
        issue(3'b000, 16'h0010, 16'h0020);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_cmd = 3'b010;
            req_a = 16'hAAAA;
            req_b = 16'h5555;
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'h0030 || rsp_err !== 1'b0 || rsp_mismatch !== 1'b0 ||
                req_ready !== 1'b0 || alu_cmd !== 3'b000 || txn_count !== exp_txn) begin
                fails++;
                $display("FAIL bp_hold%0d vld=%b data=%h err=%b mm=%b rdy=%b cmd=%h txn=%h required 1 0030 0 0 0 0 %h",
                         i, rsp_valid, rsp_data, rsp_err, rsp_mismatch, req_ready, alu_cmd, txn_count, exp_txn);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_txn++;
        @(negedge clk);
        checks++;
        if (txn_count !== exp_txn || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_release txn=%h vld=%b busy=%b required %h 0 0", txn_count, rsp_valid, busy, exp_txn);
        end
    endtask

    task automatic test_reset_mid();
        issue(3'b000, 16'h0007, 16'h0008);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, busy} !== 3'b0 || txn_count !== 16'h0 || alu_cmd !== 3'b0 || alu_ain !== 16'h0) begin
            fails++;
            $display("FAIL midrst_outputs rdy=%b vld=%b busy=%b txn=%h cmd=%h ain=%h required all 0",
                     req_ready, rsp_valid, busy, txn_count, alu_cmd, alu_ain);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_txn = 16'h0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL midrst_no_response rsp_valid=%b required 0", rsp_valid);
            end
        end
        issue(3'b000, 16'h0001, 16'h0001);
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h0002 || rsp_mismatch !== 1'b0) begin
            fails++;
            $display("FAIL midrst_add vld=%b data=%h mm=%b required 1 0002 0", rsp_valid, rsp_data, rsp_mismatch);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_txn++;
        checks++;
        if (txn_count !== 16'h0001 || txn_count !== exp_txn) begin
            fails++;
            $display("FAIL midrst_txn txn=%h required 0001", txn_count);
        end
    endtask

    task automatic test_fault();
        fault = 1'b1;
        rsp_ready = 1'b1;
        issue(3'b000, 16'h0005, 16'h0006);
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL fault_early rsp_valid=%b required 0", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h000A || rsp_mismatch !== 1'b1 || rsp_err !== 1'b0) begin
            fails++;
            $display("FAIL fault_result vld=%b data=%h mm=%b err=%b required 1 000a 1 0",
                     rsp_valid, rsp_data, rsp_mismatch, rsp_err);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        fault = 1'b0;
        exp_txn++;
        checks++;
        if (rsp_valid !== 1'b0 || txn_count !== exp_txn) begin
            fails++;
            $display("FAIL fault_handshake vld=%b txn=%h required 0 %h", rsp_valid, txn_count, exp_txn);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sequence();
        test_error();
        test_backpressure();
        test_reset_mid();
        test_fault();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
